// File: rtl/dcache_store_fwd_buf_if.sv
// dcache_store_fwd_buf_if: CPU read/store port plus memory read channel of the store-forwarding buffer.
interface dcache_store_fwd_buf_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   s_araddr;
  logic                s_arvalid;
  logic                s_arready;
  logic [DATA_W-1:0]   s_rdata;
  logic                s_rvalid;
  logic                s_rready;
  logic [ADDR_W-1:0]   s_awaddr;
  logic [DATA_W-1:0]   s_wdata;
  logic [DATA_W/8-1:0] s_wstrb;
  logic                s_wvalid;
  logic                s_wready;
  logic [ADDR_W-1:0]   m_araddr;
  logic                m_arvalid;
  logic                m_arready;
  logic [DATA_W-1:0]   m_rdata;
  logic                m_rvalid;
  logic                m_rready;
  modport slave (
    input  s_araddr, s_arvalid, s_rready, s_awaddr, s_wdata, s_wstrb, s_wvalid, m_arready, m_rdata, m_rvalid,
    output s_arready, s_rdata, s_rvalid, s_wready, m_araddr, m_arvalid, m_rready
  );
  modport master (
    output s_araddr, s_arvalid, s_rready, s_awaddr, s_wdata, s_wstrb, s_wvalid, m_arready, m_rdata, m_rvalid,
    input  s_arready, s_rdata, s_rvalid, s_wready, m_araddr, m_arvalid, m_rready
  );
endinterface

// File: rtl/dcache_store_fwd_buf.sv
// dcache_store_fwd_buf: forwards buffered cacheable stores to reads, merging over memory data on partial cover.
// Optional DCSFB_STATS_EN adds saturating fwd_hit_cnt/merge_cnt/bypass_cnt outputs.
module dcache_store_fwd_buf #(
  parameter int          DEPTH  = 8,
  parameter int          ADDR_W = 32,
  parameter int          DATA_W = 32,
  parameter logic [15:0] UC_HI0 = 16'hbfaf,
  parameter logic [15:0] UC_HI1 = 16'h9faf
) (
  input  logic        clk,
  input  logic        resetn,
`ifdef DCSFB_STATS_EN
  output logic [31:0] fwd_hit_cnt,
  output logic [31:0] merge_cnt,
  output logic [31:0] bypass_cnt,
`endif
  dcache_store_fwd_buf_if.slave bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFS_W  = $clog2(STRB_W);
  localparam int TAG_W  = ADDR_W - OFS_W;
  localparam int PTR_W  = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_AR, MEM_R, RESP} state_t;
  state_t              r_state, w_next;
  logic [TAG_W-1:0]    r_tag  [DEPTH];
  logic [DATA_W-1:0]   r_data [DEPTH];
  logic [STRB_W-1:0]   r_mask [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [ADDR_W-1:0]   r_araddr;
  logic [DATA_W-1:0]   r_rdata;
  logic                w_wuc, w_ruc, w_take, w_whit, w_rhit, w_fwd;
  logic [PTR_W-1:0]    w_widx, w_ridx;
  logic [STRB_W-1:0]   w_rmask;
  logic [DATA_W-1:0]   w_merged;
  assign w_wuc  = bus.s_awaddr[ADDR_W-1 -: 16] == UC_HI0 || bus.s_awaddr[ADDR_W-1 -: 16] == UC_HI1;
  assign w_ruc  = r_araddr[ADDR_W-1 -: 16] == UC_HI0 || r_araddr[ADDR_W-1 -: 16] == UC_HI1;
  assign w_take = bus.s_wvalid && bus.s_wready && |bus.s_wstrb;
  always_comb begin
    w_whit = 1'b0;
    w_widx = '0;
    w_rhit = 1'b0;
    w_ridx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (|r_mask[i] && r_tag[i] == bus.s_awaddr[ADDR_W-1:OFS_W]) begin
        w_whit = 1'b1;
        w_widx = PTR_W'(i);
      end
      if (|r_mask[i] && r_tag[i] == r_araddr[ADDR_W-1:OFS_W]) begin
        w_rhit = 1'b1;
        w_ridx = PTR_W'(i);
      end
    end
  end
  assign w_rmask = w_rhit ? r_mask[w_ridx] : '0;
  always_comb begin
    w_merged = bus.m_rdata;
    for (int b = 0; b < STRB_W; b++)
      w_merged[8*b +: 8] = w_rmask[b] ? r_data[w_ridx][8*b +: 8] : bus.m_rdata[8*b +: 8];
  end
  assign w_fwd = r_state == LOOKUP && !w_ruc && &w_rmask;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = bus.s_arvalid ? LOOKUP : IDLE;
      LOOKUP:  w_next = w_fwd ? RESP : MEM_AR;
      MEM_AR:  w_next = bus.m_arready ? MEM_R : MEM_AR;
      MEM_R:   w_next = bus.m_rvalid ? RESP : MEM_R;
      RESP:    w_next = bus.s_rready ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_state  <= IDLE;
      r_araddr <= '0;
      r_rdata  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && bus.s_arvalid) r_araddr <= bus.s_araddr;
      if (w_fwd) r_rdata <= r_data[w_ridx];
      if (r_state == MEM_R && bus.m_rvalid) r_rdata <= w_ruc ? bus.m_rdata : w_merged;
    end
  // Masks alone define liveness, so tag/data need no reset.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) r_mask[i] <= '0;
      r_wr_ptr <= '0;
    end else if (w_take) begin
      if (w_wuc) begin
        if (w_whit) r_mask[w_widx] <= '0;
      end else if (w_whit) begin
        r_mask[w_widx] <= r_mask[w_widx] | bus.s_wstrb;
      end else begin
        r_mask[r_wr_ptr] <= bus.s_wstrb;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
    end
  always_ff @(posedge clk)
    if (w_take && !w_wuc) begin
      if (w_whit) begin
        for (int b = 0; b < STRB_W; b++)
          if (bus.s_wstrb[b]) r_data[w_widx][8*b +: 8] <= bus.s_wdata[8*b +: 8];
      end else begin
        r_tag[r_wr_ptr]  <= bus.s_awaddr[ADDR_W-1:OFS_W];
        r_data[r_wr_ptr] <= bus.s_wdata;
      end
    end
  assign bus.s_arready = r_state == IDLE;
  assign bus.s_rvalid  = r_state == RESP;
  assign bus.s_rdata   = r_rdata;
  assign bus.s_wready  = r_state != LOOKUP;
  assign bus.m_araddr  = r_araddr;
  assign bus.m_arvalid = r_state == MEM_AR;
  assign bus.m_rready  = r_state == MEM_R;
`ifdef DCSFB_STATS_EN
  logic w_done, w_mrg, w_byp;
  assign w_done = r_state == MEM_R && bus.m_rvalid;
  assign w_mrg  = w_done && !w_ruc && w_rhit;
  assign w_byp  = w_done && (w_ruc || !w_rhit);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      fwd_hit_cnt <= '0;
      merge_cnt   <= '0;
      bypass_cnt  <= '0;
    end else begin
      if (w_fwd && ~&fwd_hit_cnt) fwd_hit_cnt <= fwd_hit_cnt + 1'b1;
      if (w_mrg && ~&merge_cnt) merge_cnt <= merge_cnt + 1'b1;
      if (w_byp && ~&bypass_cnt) bypass_cnt <= bypass_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_dcache_store_fwd_buf.sv
// tb_dcache_store_fwd_buf: scoreboard bench for the store-forwarding buffer with a delayable memory responder.
module tb_dcache_store_fwd_buf;
  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;
  dcache_store_fwd_buf_if #(.ADDR_W(32), .DATA_W(32)) bus();
`ifdef DCSFB_STATS_EN
  logic [31:0] fwd_hit_cnt, merge_cnt, bypass_cnt;
`endif
  dcache_store_fwd_buf dut (
    .clk(clk),
    .resetn(resetn),
`ifdef DCSFB_STATS_EN
    .fwd_hit_cnt(fwd_hit_cnt),
    .merge_cnt(merge_cnt),
    .bypass_cnt(bypass_cnt),
`endif
    .bus(bus)
  );
  int          n_tests = 0, n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem_data = '0;
  logic        mem_hold = 1'b0;
  int          ar_dly = 0, ar_cnt = 0, mem_reads = 0;
  int          ar_cycles = 0, ar_moves = 0;
  logic [31:0] ar_last = '0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ctl();
    return {27'b0, bus.s_arready, bus.s_rvalid, bus.m_arvalid, bus.m_rready, bus.s_wready};
  endfunction
  // memory: grants the address after ar_dly waiting cycles, returns mem_data one cycle later
  initial begin
    bus.m_arready = 1'b0;
    bus.m_rvalid  = 1'b0;
    bus.m_rdata   = '0;
    forever begin
      @(negedge clk);
      bus.m_rvalid = 1'b0;
      if (bus.m_arready) begin
        bus.m_arready = 1'b0;
        if (!mem_hold) begin
          bus.m_rvalid = 1'b1;
          bus.m_rdata  = mem_data;
        end
      end else if (bus.m_arvalid) begin
        if (ar_cnt >= ar_dly) begin
          bus.m_arready = 1'b1;
          mem_reads++;
          ar_cnt = 0;
        end else ar_cnt++;
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (bus.m_arvalid) begin
      if (ar_cycles > 0 && bus.m_araddr !== ar_last) ar_moves++;
      ar_cycles++;
      ar_last = bus.m_araddr;
    end
  end
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    @(negedge clk);
    bus.s_awaddr = a;
    bus.s_wdata  = d;
    bus.s_wstrb  = s;
    bus.s_wvalid = 1'b1;
    while (!bus.s_wready && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (!bus.s_wready) check("wready_timeout", 32'(bus.s_wready), 1);
    @(negedge clk);
    bus.s_wvalid = 1'b0;
  endtask
  task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input int rr_dly, output int lat);
    int wobble = 0;
    logic [31:0] d0;
    exp_q.push_back(exp);
    ar_cycles = 0;
    ar_moves  = 0;
    @(negedge clk);
    check("arready_idle", 32'(bus.s_arready), 1);
    bus.s_araddr  = a;
    bus.s_arvalid = 1'b1;
    @(negedge clk);
    bus.s_arvalid = 1'b0;
    lat = 1;
    while (!bus.s_rvalid && lat < 64) begin
      if (bus.s_arready) wobble++;
      @(negedge clk);
      lat++;
    end
    if (!bus.s_rvalid) begin
      check("rvalid_timeout", 32'(bus.s_rvalid), 1);
      void'(exp_q.pop_front());
      return;
    end
    d0 = bus.s_rdata;
    repeat (rr_dly) begin
      @(negedge clk);
      if (!bus.s_rvalid || bus.s_rdata !== d0 || bus.s_arready) wobble++;
    end
    bus.s_rready = 1'b1;
    check("rdata", bus.s_rdata, exp_q.pop_front());
    check("resp_stable", wobble, 0);
    @(negedge clk);
    bus.s_rready = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask
  initial begin
    int lat, r0, n;
    bus.s_araddr  = '0;
    bus.s_arvalid = 1'b0;
    bus.s_rready  = 1'b0;
    bus.s_awaddr  = '0;
    bus.s_wdata   = '0;
    bus.s_wstrb   = '0;
    bus.s_wvalid  = 1'b0;
    #1 resetn = 1'b0;
    #1;
    check("rst_ctl", ctl(), 32'b10001);
    check("rst_rdata", bus.s_rdata, 0);
    check("rst_maraddr", bus.m_araddr, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    // full-word hit
    do_store(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    r0 = mem_reads;
    do_read(32'h8000_0010, 32'hDEAD_BEEF, 0, lat);
    check("hit_lat", lat, 2);
    check("hit_no_mem", mem_reads - r0, 0);
    check("hit_no_arvalid", ar_cycles, 0);
    // partial cover merges over memory
    do_store(32'h8000_0020, 32'h0000_AB00, 4'b0010);
    mem_data = 32'h1122_3344;
    r0 = mem_reads;
    do_read(32'h8000_0020, 32'h1122_AB44, 0, lat);
    check("merge_mem", mem_reads - r0, 1);
    // nine distinct stores evict the oldest
    do_reset();
    for (int i = 0; i < 9; i++) do_store(32'h8000_0000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF);
    mem_data = 32'h5566_7788;
    r0 = mem_reads;
    do_read(32'h8000_0000, 32'h5566_7788, 0, lat);
    check("evict_mem", mem_reads - r0, 1);
    r0 = mem_reads;
    do_read(32'h8000_0020, 32'hA000_0008, 0, lat);
    check("newest_no_mem", mem_reads - r0, 0);
    do_read(32'h8000_0004, 32'hA000_0001, 0, lat);
    check("second_no_mem", mem_reads - r0, 0);
    // merge into a live entry keeps it fully covered
    do_store(32'h8000_0004, 32'h5A00_0000, 4'b1000);
    r0 = mem_reads;
    do_read(32'h8000_0004, 32'h5A00_0001, 0, lat);
    check("merge_hit_no_mem", mem_reads - r0, 0);
    // uncacheable store and read
    do_store(32'hBFAF_0000, 32'h1, 4'hF);
    mem_data = 32'h5;
    r0 = mem_reads;
    do_read(32'hBFAF_0000, 32'h5, 0, lat);
    check("uc_mem", mem_reads - r0, 1);
    r0 = mem_reads;
    do_read(32'h8000_0020, 32'hA000_0008, 0, lat);
    check("uc_buf_intact", mem_reads - r0, 0);
    // zero-strobe store is ignored
    do_store(32'h8000_0200, 32'hFFFF_FFFF, 4'h0);
    mem_data = 32'h1234_5678;
    do_read(32'h8000_0200, 32'h1234_5678, 0, lat);
    // back-pressure on both channels
    ar_dly = 3;
    mem_data = 32'hCAFE_F00D;
    do_read(32'h8000_0100, 32'hCAFE_F00D, 2, lat);
    check("ar_hold_cycles", ar_cycles, 4);
    check("ar_addr_stable", ar_moves, 0);
    ar_dly = 0;
    // reset while waiting in MEM_R
    do_store(32'h8000_0300, 32'h7777_7777, 4'hF);
    do_read(32'h8000_0300, 32'h7777_7777, 0, lat);
    mem_hold = 1'b1;
    @(negedge clk);
    bus.s_araddr  = 32'h8000_0400;
    bus.s_arvalid = 1'b1;
    @(negedge clk);
    bus.s_arvalid = 1'b0;
    n = 0;
    while (!bus.m_rready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reach_mem_r", 32'(bus.m_rready), 1);
    resetn = 1'b0;
    #1;
    check("mid_rst_ctl", ctl(), 32'b10001);
    check("mid_rst_rdata", bus.s_rdata, 0);
    check("mid_rst_maraddr", bus.m_araddr, 0);
    @(negedge clk);
    resetn   = 1'b1;
    mem_hold = 1'b0;
    mem_data = 32'h99;
    r0 = mem_reads;
    do_read(32'h8000_0300, 32'h99, 0, lat);
    check("rst_clears_buf", mem_reads - r0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end
endmodule
